// File: rtl/mpu_arith_pkg.sv
// Shared constants and packer state encoding for the packed-lane arithmetic path.
package mpu_arith_pkg;

  localparam int unsigned DEF_NUM_BITS = 512;
  localparam int unsigned DEF_LANE_W   = 8;
  localparam int unsigned DEF_BEAT_W   = 64;
  localparam int unsigned DEF_BEATS    = DEF_NUM_BITS / DEF_BEAT_W;

  typedef logic [1:0] pack_state_t;

  localparam pack_state_t LOAD_D = 2'd0;
  localparam pack_state_t LOAD_A = 2'd1;
  localparam pack_state_t ISSUE  = 2'd2;

endpackage

// File: rtl/packer_beat_ctr.sv
// Beat index counter for operand packing/unpacking; wraps to zero after the last beat.
module packer_beat_ctr
  import mpu_arith_pkg::*;
#(
  parameter int unsigned BEATS = DEF_BEATS,
  parameter int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          last
);

  assign last = (cnt == CW'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/lane_operand_packer.sv
// Assembles a full-width minuend/subtrahend pair from narrow beats and holds it for the subtractor.
// Optional LANE_OPERAND_PACKER_PERF_EN adds a 32-bit issued-pair counter output.
module lane_operand_packer
  import mpu_arith_pkg::*;
#(
  parameter int unsigned NUM_BITS = DEF_NUM_BITS,
  parameter int unsigned BEAT_W   = DEF_BEAT_W,
  parameter int unsigned LANE_W   = DEF_LANE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [BEAT_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [NUM_BITS-1:0] dd,
  output logic [NUM_BITS-1:0] aa,
  output logic                out_valid,
`ifdef LANE_OPERAND_PACKER_PERF_EN
  output logic [31:0]         pair_count,
`endif
  input  logic                out_ready
);

  localparam int unsigned BEATS = NUM_BITS / BEAT_W;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if ((NUM_BITS % BEAT_W) != 0 || (BEAT_W % LANE_W) != 0) begin : g_bad_geometry
    $error("lane_operand_packer: beats must tile the operand and lanes must tile a beat");
  end

  pack_state_t   state;
  pack_state_t   state_nxt;
  logic [CW-1:0] cnt;
  logic          last;
  logic          accept;
  logic          handshake;

  assign in_ready  = (state == LOAD_D) || (state == LOAD_A);
  assign accept    = in_valid & in_ready;
  assign handshake = (state == ISSUE) & out_ready;

  packer_beat_ctr #(
    .BEATS (BEATS),
    .CW    (CW)
  ) u_beat_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept),
    .clr   (flush),
    .cnt   (cnt),
    .last  (last)
  );

  // Next-state: load minuend, load subtrahend, then hold until consumed
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_D:  if (accept && last) state_nxt = LOAD_A;
      LOAD_A:  if (accept && last) state_nxt = ISSUE;
      ISSUE:   if (out_ready)      state_nxt = LOAD_D;
      default: state_nxt = LOAD_D;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state     <= LOAD_D;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt == ISSUE);
    end
  end

  // Beat k lands in slice k of the operand being loaded; a consumed pair is cleared
  always_ff @(posedge clk) begin
    if (!rst_n || flush || handshake) begin
      dd <= '0;
      aa <= '0;
    end else if (accept) begin
      for (int unsigned b = 0; b < BEATS; b++) begin
        if (cnt == CW'(b)) begin
          if (state == LOAD_D) dd[b*BEAT_W +: BEAT_W] <= in_data;
          else                 aa[b*BEAT_W +: BEAT_W] <= in_data;
        end
      end
    end
  end

`ifdef LANE_OPERAND_PACKER_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      pair_count <= '0;
    end else if (handshake) begin
      pair_count <= pair_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lane_operand_packer.sv
// Randomized and directed bench for lane_operand_packer against a beat-count reference model.
module tb_lane_operand_packer;

  localparam int unsigned NB    = 512;
  localparam int unsigned BW    = 64;
  localparam int unsigned BEATS = NB / BW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [BW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] dd;
  logic [NB-1:0] aa;
  logic          out_valid;
  logic          out_ready;
`ifdef LANE_OPERAND_PACKER_PERF_EN
  logic [31:0]   pair_count;
`endif

  lane_operand_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dd         (dd),
    .aa         (aa),
    .out_valid  (out_valid),
`ifdef LANE_OPERAND_PACKER_PERF_EN
    .pair_count (pair_count),
`endif
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a pair is just the count of beats accepted so far plus the beats themselves
  int            m_k = 0;
  logic [NB-1:0] m_dd = '0;
  logic [NB-1:0] m_aa = '0;
  int unsigned   m_pc = 0;
  bit            chk_en = 1'b0;

  always @(posedge clk) begin
    if (!rst_n || flush) begin
      m_k = 0; m_dd = '0; m_aa = '0; m_pc = 0;
      chk_en = 1'b1;
    end else if (m_k < 2 * BEATS) begin
      if (in_valid) begin
        if (m_k < BEATS) m_dd[m_k*BW +: BW] = in_data;
        else             m_aa[(m_k-BEATS)*BW +: BW] = in_data;
        m_k++;
      end
    end else if (out_ready) begin
      m_k = 0; m_dd = '0; m_aa = '0; m_pc++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("in_ready",  NB'(in_ready),  NB'(m_k < 2 * BEATS));
      chk("out_valid", NB'(out_valid), NB'(m_k == 2 * BEATS));
      chk("dd", dd, m_dd);
      chk("aa", aa, m_aa);
`ifdef LANE_OPERAND_PACKER_PERF_EN
      chk("pair_count", NB'(pair_count), NB'(m_pc));
`endif
    end
  end

  task automatic cyc(input logic v, input logic [BW-1:0] d, input logic ordy, input logic fl);
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = ordy; flush = fl;
    @(posedge clk);
  endtask

  // Streams 2*BEATS beats; with gap set, an idle cycle follows each beat
  task automatic load_pair(input logic [NB-1:0] d, input logic [NB-1:0] a, input bit gap);
    logic [BW-1:0] b;
    for (int k = 0; k < 2 * BEATS; k++) begin
      b = (k < BEATS) ? d[k*BW +: BW] : a[(k-BEATS)*BW +: BW];
      cyc(1'b1, b, 1'b0, 1'b0);
      if (gap && k < 2 * BEATS - 1) begin
        #1;
        chk("stall_no_valid", NB'(out_valid), NB'(0));
        cyc(1'b0, ~b, 1'b1, 1'b0);
      end
    end
    #1;
  endtask

  task automatic release_pair();
    cyc(1'b0, '0, 1'b1, 1'b0);
    #1;
    chk("rel_out_valid", NB'(out_valid), NB'(0));
    chk("rel_dd", dd, '0);
    chk("rel_aa", aa, '0);
  endtask

  logic [NB-1:0] d_v, a_v;
  logic [7:0]    diff;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", NB'(out_valid), NB'(0));
    chk("reset_in_ready",  NB'(in_ready),  NB'(1));
    chk("reset_dd", dd, '0);
    @(negedge clk); rst_n = 1'b1;

    // Lane-0 pair
    d_v = NB'(8'h43); a_v = NB'(8'h02);
    load_pair(d_v, a_v, 1'b0);
    chk("l0_out_valid", NB'(out_valid), NB'(1));
    chk("l0_in_ready",  NB'(in_ready),  NB'(0));
    chk("l0_dd", dd, NB'(8'h43));
    chk("l0_aa", aa, NB'(8'h02));
    chk("l0_model_dd", m_dd, NB'(8'h43));
    diff = dd[7:0] - aa[7:0];
    chk("l0_diff", NB'(diff), NB'(8'h41));
    release_pair();

    // Borrow lane: single bit at 256 in subtrahend
    d_v = '0; a_v = '0; a_v[4*BW] = 1'b1;
    load_pair(d_v, a_v, 1'b0);
    chk("borrow_aa", aa, NB'(1) << 256);
    chk("borrow_dd", dd, '0);
    release_pair();

    // Top lane, held for 5 cycles
    d_v = '0; a_v = '0; d_v[511:504] = 8'h33; a_v[511:504] = 8'h05;
    load_pair(d_v, a_v, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, '1, 1'b0, 1'b0);
      #1;
      chk("hold_out_valid", NB'(out_valid), NB'(1));
      chk("hold_dd", NB'(dd[511:504]), NB'(8'h33));
      chk("hold_aa", NB'(aa[511:504]), NB'(8'h05));
    end
    diff = dd[511:504] - aa[511:504];
    chk("top_diff", NB'(diff), NB'(8'h2E));
    release_pair();

    // Stalls between beats
    load_pair(NB'(8'h43), NB'(8'h02), 1'b1);
    chk("stall_out_valid", NB'(out_valid), NB'(1));
    chk("stall_dd", dd, NB'(8'h43));
    chk("stall_aa", aa, NB'(8'h02));
    release_pair();

    // Flush after three D beats, then a clean pair
    for (int i = 0; i < 3; i++) cyc(1'b1, BW'(64'h1111 * (i + 1)), 1'b0, 1'b0);
    cyc(1'b1, '1, 1'b1, 1'b1);
    #1;
    chk("flush_dd", dd, '0);
    chk("flush_in_ready", NB'(in_ready), NB'(1));
    d_v = {16{32'hA5A5_0F0F}}; a_v = {16{32'h1234_5678}};
    load_pair(d_v, a_v, 1'b0);
    chk("post_flush_dd", dd, {16{32'hA5A5_0F0F}});
    chk("post_flush_aa", aa, {16{32'h1234_5678}});

    // Reset during ISSUE
    @(negedge clk); rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_issue_out_valid", NB'(out_valid), NB'(0));
    @(negedge clk); rst_n = 1'b1;

`ifdef LANE_OPERAND_PACKER_PERF_EN
    for (int p = 0; p < 3; p++) begin
      load_pair({16{$urandom}}, {16{$urandom}}, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    #1;
    chk("perf_three", NB'(pair_count), NB'(3));
    cyc(1'b0, '0, 1'b0, 1'b1);
    #1;
    chk("perf_flush", NB'(pair_count), NB'(0));
`endif

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 2) == 0);
      flush     = ($urandom_range(0, 63) == 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      @(posedge clk);
    end
    @(negedge clk);
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
